mux_n21_pipe: RTL and testbench
===============================

Name: mux_n21_pipe

Overview:
- Parametrised N:1 select mux with a registered output, for pipeline forwarding and writeback paths of the MIPS datapath.
- Generalises the fixed 4:1 combinational select to any input count and data width.
- Adds a valid qualifier, stall (hold), flush (bubble) and out-of-range select detection.
- Output is a pipeline register, so it drops directly between stages.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of inputs; range 2..16; need not be a power of two.
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden.

Ports:
- w_clk  input  1  clock; all state updates on rising edge.
- w_rst_n  input  1  asynchronous active-low reset.
- w_input_x  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- w_ctrl_x  input  SEL_W  select.
- w_valid_in_1  input  1  input data/select qualifier.
- w_stall_1  input  1  hold all output state.
- w_flush_1  input  1  insert bubble.
- w_err_clr_1  input  1  clear sticky error.
- w_out_x  output  WIDTH  registered selected data.
- w_valid_out_1  output  1  registered valid.
- w_sel_out_x  output  SEL_W  registered copy of the select used for w_out_x.
- w_sel_err_1  output  1  sticky out-of-range select flag.

Behaviour:
- Reset is asynchronous on w_rst_n low, independent of w_clk. All outputs go to 0: w_out_x, w_valid_out_1, w_sel_out_x, w_sel_err_1.
- Latency is 1 cycle. Inputs sampled at edge t appear on the outputs after edge t.
- Per-edge priority: flush > stall > load.
  - Flush: w_valid_out_1<=0 and w_out_x<=0; w_sel_out_x holds.
  - Stall (no flush): every output register holds, including w_sel_err_1 set logic.
  - Load: w_out_x <= input[w_ctrl_x]; w_sel_out_x <= w_ctrl_x; w_valid_out_1 <= w_valid_in_1.
- Data loads regardless of valid. With w_valid_in_1=0 the data is don't-care, but the registers still update, so invalid cycles never leave stale valid data.
- Out-of-range select (w_ctrl_x >= NUM_IN, possible only when NUM_IN is not a power of two) on a load cycle:
  - w_out_x <= 0 and w_sel_out_x <= w_ctrl_x.
  - If w_valid_in_1=1, w_sel_err_1 <= 1. Invalid out-of-range cycles do not set the error.
- w_sel_err_1 is sticky until w_err_clr_1=1 at an edge. If set and clear coincide, set wins and the flag stays 1.
- w_err_clr_1 acts even during stall or flush.
- No combinational path from any input to any output.
- Reset asserted mid-stream discards the in-flight value. The first load after release behaves as a normal load.

Optional Feature:
- MUX_PIPE2_EN defined: adds a second register stage after the first.
  - Latency becomes 2. Outputs come from stage 2.
  - Stall holds both stages. Flush clears valid and data in both stages.
  - Error detection stays on stage-1 load; w_sel_err_1 is asserted in step with stage 1, 1 cycle before the data leaves stage 2.
- MUX_PIPE2_EN undefined: single stage, 1-cycle latency as above.

Test Plan:
- Reset: w_rst_n=0 asynchronously between edges -> all outputs 0 immediately; after release, first output is 0 with w_valid_out_1=0.
- Sweep, NUM_IN=4, WIDTH=32, inputs 0x11111111/0x22222222/0x33333333/0x44444444: sel 0,1,2,3 with valid=1 on consecutive cycles -> w_out_x follows 1 cycle later, w_sel_out_x=0..3, valid=1.
- Stall/flush: load 0x33333333 (sel=2), then stall 3 cycles while sel=0 -> output holds 0x33333333; then stall and flush together -> valid=0, w_out_x=0.
- Out of range, NUM_IN=5, sel=7:
  - valid=0 -> w_out_x=0, w_sel_err_1 stays 0.
  - valid=1 -> w_out_x=0, w_sel_err_1=1 and stays 1.
  - w_err_clr_1 alone -> 0; clear with a simultaneous valid error -> stays 1.
- MUX_PIPE2_EN: sel=1, valid=1 -> 0x22222222 appears 2 cycles later; a flush in between -> valid=0 at both stages.

Source files
------------

// File: rtl/mux_n21_pipe_if.sv
// rtl/mux_n21_pipe_if.sv - select/data bundle for the pipelined N:1 forwarding mux
interface mux_n21_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] w_input_x;
  logic [SEL_W-1:0]        w_ctrl_x;
  logic                    w_valid_in_1;
  logic                    w_stall_1;
  logic                    w_flush_1;
  logic                    w_err_clr_1;
  logic [WIDTH-1:0]        w_out_x;
  logic                    w_valid_out_1;
  logic [SEL_W-1:0]        w_sel_out_x;
  logic                    w_sel_err_1;

  // Upstream side: supplies candidates, select and pipeline control.
  modport master (
    output w_input_x, w_ctrl_x, w_valid_in_1, w_stall_1, w_flush_1, w_err_clr_1,
    input  w_out_x, w_valid_out_1, w_sel_out_x, w_sel_err_1
  );

  // Mux side: consumes candidates and presents the registered result.
  modport slave (
    input  w_input_x, w_ctrl_x, w_valid_in_1, w_stall_1, w_flush_1, w_err_clr_1,
    output w_out_x, w_valid_out_1, w_sel_out_x, w_sel_err_1
  );
endinterface

// File: rtl/mux_n21_pipe.sv
// rtl/mux_n21_pipe.sv - N:1 select mux with registered output; MUX_PIPE2_EN adds a second stage
module mux_n21_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  mux_n21_pipe_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  logic [31:0]      sel_wide;
  logic             load;
  logic             err_set;

  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;
  logic [SEL_W-1:0] s1_sel;
  logic             sel_err;

  assign load     = !bus.w_flush_1 && !bus.w_stall_1;
  assign sel_wide = 32'(bus.w_ctrl_x);
  assign sel_oor  = (sel_wide >= 32'(NUM_IN));
  // Only a qualified load may raise the error; stalled or flushed cycles never do.
  assign err_set  = load && bus.w_valid_in_1 && sel_oor;

  // Select the addressed candidate; an unmatched (out-of-range) select yields zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.w_ctrl_x == SEL_W'(k)) begin
        sel_data = bus.w_input_x[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage 1: flush bubbles data/valid but keeps the last select, stall holds everything.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_sel   <= '0;
    end else if (bus.w_flush_1) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (!bus.w_stall_1) begin
      s1_data  <= sel_data;
      s1_valid <= bus.w_valid_in_1;
      s1_sel   <= bus.w_ctrl_x;
    end
  end

  // Sticky select error: a new error beats a simultaneous clear, clear works even while held.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sel_err <= 1'b0;
    end else if (err_set) begin
      sel_err <= 1'b1;
    end else if (bus.w_err_clr_1) begin
      sel_err <= 1'b0;
    end
  end

  assign bus.w_sel_err_1 = sel_err;

`ifdef MUX_PIPE2_EN
  logic [WIDTH-1:0] s2_data;
  logic             s2_valid;
  logic [SEL_W-1:0] s2_sel;

  // Stage 2: same hold/bubble rules as stage 1 so both stages move in lockstep.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
      s2_sel   <= '0;
    end else if (bus.w_flush_1) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else if (!bus.w_stall_1) begin
      s2_data  <= s1_data;
      s2_valid <= s1_valid;
      s2_sel   <= s1_sel;
    end
  end

  assign bus.w_out_x       = s2_data;
  assign bus.w_valid_out_1 = s2_valid;
  assign bus.w_sel_out_x   = s2_sel;
`else
  assign bus.w_out_x       = s1_data;
  assign bus.w_valid_out_1 = s1_valid;
  assign bus.w_sel_out_x   = s1_sel;
`endif

endmodule

// File: tb/tb_mux_n21_pipe.sv
// tb/tb_mux_n21_pipe.sv - scoreboard bench for mux_n21_pipe (4-input and 5-input instances)
module tb_mux_n21_pipe;
  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    logic [2:0]  sel;
    logic        err;
  } exp_t;

  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  exp_t q4[$];
  exp_t q5[$];
  exp_t s1_prev[2];
  exp_t s2_m[2];
  exp_t m4;
  exp_t m5;

  mux_n21_pipe_if #(.WIDTH(32), .NUM_IN(4)) b4();
  mux_n21_pipe_if #(.WIDTH(32), .NUM_IN(5)) b5();

  mux_n21_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (.w_clk(w_clk), .w_rst_n(w_rst_n), .bus(b4));
  mux_n21_pipe #(.WIDTH(32), .NUM_IN(5)) u5 (.w_clk(w_clk), .w_rst_n(w_rst_n), .bus(b5));

  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_zero_all(input string tag);
    check({tag, "_out4"}, b4.w_out_x, 32'h0);
    check({tag, "_vld4"}, 32'(b4.w_valid_out_1), 32'h0);
    check({tag, "_sel4"}, 32'(b4.w_sel_out_x), 32'h0);
    check({tag, "_err4"}, 32'(b4.w_sel_err_1), 32'h0);
    check({tag, "_out5"}, b5.w_out_x, 32'h0);
    check({tag, "_vld5"}, 32'(b5.w_valid_out_1), 32'h0);
    check({tag, "_sel5"}, 32'(b5.w_sel_out_x), 32'h0);
    check({tag, "_err5"}, 32'(b5.w_sel_err_1), 32'h0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      s1_prev[i] = '0;
      s2_m[i]    = '0;
    end
  endtask

  // One cycle of stimulus on DUT d (0: 4-input, 1: 5-input) with its hand-computed
  // stage-1 result; the scoreboard entry is pushed before the capturing edge.
  task automatic apply(input int d, input logic [2:0] sel, input logic v, input logic st,
                       input logic fl, input logic clr, input logic [31:0] ed,
                       input logic ev, input logic [2:0] es, input logic ee);
    exp_t e;
    exp_t o;
    @(negedge w_clk);
    if (d == 0) begin
      b4.w_ctrl_x = sel[1:0]; b4.w_valid_in_1 = v; b4.w_stall_1 = st;
      b4.w_flush_1 = fl; b4.w_err_clr_1 = clr;
    end else begin
      b5.w_ctrl_x = sel; b5.w_valid_in_1 = v; b5.w_stall_1 = st;
      b5.w_flush_1 = fl; b5.w_err_clr_1 = clr;
    end
    e = '{data: ed, valid: ev, sel: es, err: ee};
    o = e;
`ifdef MUX_PIPE2_EN
    if (fl) begin
      s2_m[d].data  = 32'h0;
      s2_m[d].valid = 1'b0;
    end else if (!st) begin
      s2_m[d] = s1_prev[d];
    end
    o = '{data: s2_m[d].data, valid: s2_m[d].valid, sel: s2_m[d].sel, err: ee};
    s1_prev[d] = e;
`endif
    if (d == 0) q4.push_back(o);
    else q5.push_back(o);
  endtask

  task automatic idle_inputs();
    b4.w_ctrl_x = '0; b4.w_valid_in_1 = 0; b4.w_stall_1 = 0; b4.w_flush_1 = 0; b4.w_err_clr_1 = 0;
    b5.w_ctrl_x = '0; b5.w_valid_in_1 = 0; b5.w_stall_1 = 0; b5.w_flush_1 = 0; b5.w_err_clr_1 = 0;
  endtask

  // Monitor: compare each registered result one step after its capturing edge.
  always @(posedge w_clk) begin
    #1;
    if (q4.size() > 0) begin
      m4 = q4.pop_front();
      check("d4_out", b4.w_out_x, m4.data);
      check("d4_valid", 32'(b4.w_valid_out_1), 32'(m4.valid));
      check("d4_sel", 32'(b4.w_sel_out_x), 32'(m4.sel[1:0]));
      check("d4_err", 32'(b4.w_sel_err_1), 32'(m4.err));
    end
    if (q5.size() > 0) begin
      m5 = q5.pop_front();
      check("d5_out", b5.w_out_x, m5.data);
      check("d5_valid", 32'(b5.w_valid_out_1), 32'(m5.valid));
      check("d5_sel", 32'(b5.w_sel_out_x), 32'(m5.sel));
      check("d5_err", 32'(b5.w_sel_err_1), 32'(m5.err));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    b4.w_input_x = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b5.w_input_x = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    idle_inputs();
    clear_model();
    #2;
    check_zero_all("rst_hold");
    @(negedge w_clk);
    w_rst_n = 1'b1;
    #1;
    check_zero_all("rst_release");

    // Sweep all four inputs, then an invalid load.
    apply(0, 3'd0, 1, 0, 0, 0, 32'h11111111, 1, 3'd0, 0);
    apply(0, 3'd1, 1, 0, 0, 0, 32'h22222222, 1, 3'd1, 0);
    apply(0, 3'd2, 1, 0, 0, 0, 32'h33333333, 1, 3'd2, 0);
    apply(0, 3'd3, 1, 0, 0, 0, 32'h44444444, 1, 3'd3, 0);
    apply(0, 3'd1, 0, 0, 0, 0, 32'h22222222, 0, 3'd1, 0);
    // Load then stall three cycles with a different select, then stall+flush.
    apply(0, 3'd2, 1, 0, 0, 0, 32'h33333333, 1, 3'd2, 0);
    apply(0, 3'd0, 1, 1, 0, 0, 32'h33333333, 1, 3'd2, 0);
    apply(0, 3'd0, 1, 1, 0, 0, 32'h33333333, 1, 3'd2, 0);
    apply(0, 3'd0, 1, 1, 0, 0, 32'h33333333, 1, 3'd2, 0);
    apply(0, 3'd0, 1, 1, 1, 0, 32'h00000000, 0, 3'd2, 0);
    apply(0, 3'd3, 1, 0, 0, 0, 32'h44444444, 1, 3'd3, 0);
    apply(0, 3'd1, 1, 0, 1, 0, 32'h00000000, 0, 3'd3, 0);
    apply(0, 3'd1, 1, 0, 0, 0, 32'h22222222, 1, 3'd1, 0);
    apply(0, 3'd1, 1, 0, 0, 0, 32'h22222222, 1, 3'd1, 0);
    apply(0, 3'd2, 0, 0, 0, 0, 32'h33333333, 0, 3'd2, 0);
    @(negedge w_clk);
    idle_inputs();

    // Mid-stream asynchronous reset, away from any edge.
    apply(0, 3'd1, 1, 0, 0, 0, 32'h22222222, 1, 3'd1, 0);
    @(posedge w_clk);
    #3;
    w_rst_n = 1'b0;
    #1;
    check_zero_all("rst_async");
    @(negedge w_clk);
    w_rst_n = 1'b1;
    clear_model();
    #1;
    check_zero_all("rst_after");
    apply(0, 3'd0, 1, 0, 0, 0, 32'h11111111, 1, 3'd0, 0);
    apply(0, 3'd3, 1, 0, 0, 0, 32'h44444444, 1, 3'd3, 0);
    @(negedge w_clk);
    idle_inputs();

    // Five-input instance: out-of-range selects and the sticky error flag.
    apply(1, 3'd7, 0, 0, 0, 0, 32'h00000000, 0, 3'd7, 0);
    apply(1, 3'd4, 1, 0, 0, 0, 32'h55555555, 1, 3'd4, 0);
    apply(1, 3'd7, 1, 0, 0, 0, 32'h00000000, 1, 3'd7, 1);
    apply(1, 3'd0, 1, 0, 0, 0, 32'h11111111, 1, 3'd0, 1);
    apply(1, 3'd0, 1, 0, 0, 1, 32'h11111111, 1, 3'd0, 0);
    apply(1, 3'd5, 1, 0, 0, 1, 32'h00000000, 1, 3'd5, 1);
    apply(1, 3'd1, 1, 1, 0, 1, 32'h00000000, 1, 3'd5, 0);
    apply(1, 3'd7, 1, 1, 0, 0, 32'h00000000, 1, 3'd5, 0);
    apply(1, 3'd6, 1, 0, 1, 0, 32'h00000000, 0, 3'd5, 0);
    apply(1, 3'd6, 0, 0, 0, 0, 32'h00000000, 0, 3'd6, 0);
    apply(1, 3'd2, 1, 0, 0, 0, 32'h33333333, 1, 3'd2, 0);
    apply(1, 3'd2, 1, 0, 0, 0, 32'h33333333, 1, 3'd2, 0);
    @(negedge w_clk);
    idle_inputs();

    repeat (3) @(posedge w_clk);
    #2;
    check("drain4", 32'(q4.size()), 32'h0);
    check("drain5", 32'(q5.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
